// File: rtl/code_conv_pipe.sv
// rtl/code_conv_pipe.sv - two-stage valid/ready binary/Gray/BCD/excess-3 code converter
// S1 captures word+mode, S2 holds the converted word; counters track delivered words.
module code_conv_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] conv_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int NIB = WIDTH / 4;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [1:0]       r_s1_mode;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;
    logic             r_s2_err;
    logic [CNT_W-1:0] r_conv_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_s2_load;
    logic             w_accept;
    logic             w_out_hs;
    logic [WIDTH-1:0] w_gray;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_xs3;
    logic [WIDTH-1:0] w_bcd;
    logic             w_xs3_err;
    logic             w_bcd_err;
    logic [WIDTH-1:0] w_conv_data;
    logic             w_conv_err;

    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_accept  = in_valid && in_ready;
    assign w_out_hs  = r_s2_valid && out_ready;

    assign w_gray = r_s1_data ^ (r_s1_data >> 1);

    // Gray decode is a running XOR from the MSB down.
    always_comb begin
        logic [WIDTH-1:0] v_bin;
        v_bin = '0;
        v_bin[WIDTH-1] = r_s1_data[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            v_bin[i] = v_bin[i+1] ^ r_s1_data[i];
        end
        w_bin = v_bin;
    end

    // Invalid digits are still converted modulo 16, only flagged.
    always_comb begin
        logic [3:0] v_nib;
        w_xs3     = '0;
        w_bcd     = '0;
        w_xs3_err = 1'b0;
        w_bcd_err = 1'b0;
        for (int n = 0; n < NIB; n++) begin
            v_nib = r_s1_data[4*n +: 4];
            w_xs3[4*n +: 4] = v_nib + 4'd3;
            w_bcd[4*n +: 4] = v_nib - 4'd3;
            if (v_nib > 4'd9) begin
                w_xs3_err = 1'b1;
            end
            if ((v_nib < 4'd3) || (v_nib > 4'd12)) begin
                w_bcd_err = 1'b1;
            end
        end
    end

    always_comb begin
        w_conv_data = w_gray;
        w_conv_err  = 1'b0;
        case (r_s1_mode)
            2'd0: begin
                w_conv_data = w_gray;
                w_conv_err  = 1'b0;
            end
            2'd1: begin
                w_conv_data = w_bin;
                w_conv_err  = 1'b0;
            end
            2'd2: begin
                w_conv_data = w_xs3;
                w_conv_err  = w_xs3_err;
            end
            default: begin
                w_conv_data = w_bcd;
                w_conv_err  = w_bcd_err;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= 2'd0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= in_data;
            r_s1_mode  <= in_mode;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_data  <= w_conv_data;
            r_s2_err   <= w_conv_err;
        end else if (w_out_hs) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conv_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_out_hs) begin
            if (r_conv_cnt != '1) begin
                r_conv_cnt <= r_conv_cnt + CNT_W'(1);
            end
            if (r_s2_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_err   = r_s2_err;
    assign conv_cnt  = r_conv_cnt;
    assign err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_code_conv_pipe.sv
// tb/tb_code_conv_pipe.sv - self-checking bench for code_conv_pipe
// Three instances: WIDTH=4/CNT_W=8, WIDTH=8/CNT_W=8, WIDTH=4/CNT_W=3.
module tb_code_conv_pipe;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]      iv;
    logic [N-1:0][7:0] id;
    logic [N-1:0][1:0] im;
    logic [N-1:0]      ordy;
    wire  [N-1:0]      ir;
    wire  [N-1:0]      ov;
    wire  [N-1:0][7:0] od;
    wire  [N-1:0]      oe;
    wire  [N-1:0][7:0] cc;
    wire  [N-1:0][7:0] ec;

    int checks = 0;
    int errors = 0;
    int mcnt[N];
    int merr[N];

    logic [7:0] tx_d[$];
    logic [1:0] tx_m[$];
    logic [7:0] got_d[$];
    logic       got_e[$];

    always #5 clk = ~clk;

    assign od[0][7:4] = 4'h0;
    assign od[2][7:4] = 4'h0;
    assign cc[2][7:3] = 5'h0;
    assign ec[2][7:3] = 5'h0;

    code_conv_pipe #(.WIDTH(4), .CNT_W(8)) u_w4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0][3:0]), .in_mode(im[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0][3:0]), .out_err(oe[0]),
        .conv_cnt(cc[0]), .err_cnt(ec[0])
    );

    code_conv_pipe #(.WIDTH(8), .CNT_W(8)) u_w8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_mode(im[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_err(oe[1]),
        .conv_cnt(cc[1]), .err_cnt(ec[1])
    );

    code_conv_pipe #(.WIDTH(4), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2][3:0]), .in_mode(im[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2][3:0]), .out_err(oe[2]),
        .conv_cnt(cc[2][2:0]), .err_cnt(ec[2][2:0])
    );

    function automatic int wk(int k);
        return (k == 1) ? 8 : 4;
    endfunction

    function automatic int cmax(int k);
        return (k == 2) ? 7 : 255;
    endfunction

    // Reference conversion straight from the code definitions: {err, data}.
    function automatic logic [8:0] ref_conv(int w, logic [7:0] din, logic [1:0] m);
        int d, x, r;
        bit e;
        d = int'(din) & ((1 << w) - 1);
        r = 0;
        e = 1'b0;
        case (m)
            2'd0: r = d ^ (d >> 1);
            2'd1: for (int s = 0; s < w; s++) r = r ^ (d >> s);
            default: begin
                for (int n = 0; n < w / 4; n++) begin
                    x = (d >> (4 * n)) & 15;
                    if (m == 2'd2) begin
                        if (x > 9) e = 1'b1;
                        x = (x + 3) % 16;
                    end else begin
                        if (x < 3 || x > 12) e = 1'b1;
                        x = (x + 13) % 16;
                    end
                    r = r | (x << (4 * n));
                end
            end
        endcase
        return {e, r[7:0]};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(logic [7:0] d, logic [1:0] m);
        tx_d.push_back(d);
        tx_m.push_back(m);
    endtask

    // Streams tx_d/tx_m into instance k, checking every cycle against the model.
    task automatic stream(int k, int rdy_pct, bit chk_lat);
        logic [7:0] ed[$];
        logic       ee[$];
        int         et[$];
        int         sent = 0;
        int         done = 0;
        int         it = 0;
        int         n;
        bit         stall = 1'b0;
        logic [7:0] pd = 8'h0;
        logic       pe = 1'b0;
        logic [8:0] r;
        n = tx_d.size();
        got_d.delete();
        got_e.delete();
        while (done < n && it < 2000) begin
            @(negedge clk);
            ordy[k] = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
            if (sent < n) begin
                iv[k] = 1'b1;
                id[k] = tx_d[sent];
                im[k] = tx_m[sent];
            end else begin
                iv[k] = 1'b0;
            end
            #1;
            if (stall) begin
                chk("hold_valid", ov[k], 1);
                chk("hold_data", od[k], pd);
                chk("hold_err", oe[k], pe);
            end
            chk("in_ready", ir[k], ((sent - done) < 2) || ordy[k]);
            if (ov[k] && ordy[k]) begin
                if (ed.size() == 0) begin
                    chk("spurious_out", ov[k], 0);
                end else begin
                    chk("data", od[k], ed[0]);
                    chk("err", oe[k], ee[0]);
                    if (chk_lat) chk("latency", it - et[0], 2);
                    got_d.push_back(od[k]);
                    got_e.push_back(oe[k]);
                    if (mcnt[k] < cmax(k)) mcnt[k]++;
                    if (ee[0] && merr[k] < cmax(k)) merr[k]++;
                    void'(ed.pop_front());
                    void'(ee.pop_front());
                    void'(et.pop_front());
                    done++;
                end
            end
            if (iv[k] && ir[k]) begin
                r = ref_conv(wk(k), tx_d[sent], tx_m[sent]);
                ed.push_back(r[7:0]);
                ee.push_back(r[8]);
                et.push_back(it);
                sent++;
            end
            stall = ov[k] && !ordy[k];
            pd = od[k];
            pe = oe[k];
            it++;
        end
        @(negedge clk);
        iv[k] = 1'b0;
        ordy[k] = 1'b1;
        #1;
        if (done < n) chk("stream_timeout", done, n);
        chk("conv_cnt", cc[k], mcnt[k]);
        chk("err_cnt", ec[k], merr[k]);
        tx_d.delete();
        tx_m.delete();
    endtask

    initial begin
        iv = '0;
        id = '0;
        im = '0;
        ordy = '1;
        for (int k = 0; k < N; k++) begin
            mcnt[k] = 0;
            merr[k] = 0;
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("rst_out_valid", ov[k], 0);
            chk("rst_out_data", od[k], 0);
            chk("rst_out_err", oe[k], 0);
            chk("rst_conv_cnt", cc[k], 0);
            chk("rst_err_cnt", ec[k], 0);
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                chk("idle_in_ready", ir[k], 1);
                chk("idle_out_valid", ov[k], 0);
            end
        end

        // All 16 codes binary->Gray, then Gray->binary, back-to-back.
        for (int i = 0; i < 16; i++) push(8'(i), 2'd0);
        for (int i = 0; i < 16; i++) push(8'(i), 2'd1);
        stream(0, 100, 1'b1);
        chk("bin2gray_1011", got_d[11], 8'h0E);
        chk("gray2bin_1110", got_d[30], 8'h0B);
        chk("conv_cnt_32", cc[0], 32);

        push(8'h05, 2'd2);
        push(8'h0A, 2'd2);
        push(8'h08, 2'd3);
        push(8'h01, 2'd3);
        stream(0, 100, 1'b1);
        chk("xs3_0101", got_d[0], 8'h08);
        chk("xs3_0101_err", got_e[0], 0);
        chk("xs3_1010", got_d[1], 8'h0D);
        chk("xs3_1010_err", got_e[1], 1);
        chk("bcd_1000", got_d[2], 8'h05);
        chk("bcd_0001", got_d[3], 8'h0E);
        chk("bcd_0001_err", got_e[3], 1);
        chk("err_cnt_2", ec[0], 2);

        for (int i = 0; i < 6; i++) push(8'($urandom_range(15)), 2'($urandom_range(3)));
        stream(0, 50, 1'b0);

        push(8'h59, 2'd2);
        push(8'hFF, 2'd0);
        push(8'hA3, 2'd2);
        push(8'h3C, 2'd3);
        for (int i = 0; i < 12; i++) push(8'($urandom_range(255)), 2'(i % 4));
        stream(1, 100, 1'b1);
        chk("w8_xs3_59", got_d[0], 8'h8C);
        chk("w8_xs3_59_err", got_e[0], 0);
        chk("w8_gray_ff", got_d[1], 8'h80);
        chk("w8_xs3_a3", got_d[2], 8'hD6);
        chk("w8_xs3_a3_err", got_e[2], 1);

        for (int i = 0; i < 20; i++) push(8'($urandom_range(255)), 2'($urandom_range(3)));
        stream(1, 60, 1'b0);

        for (int i = 0; i < 10; i++) push(8'($urandom_range(15)), 2'($urandom_range(3)));
        stream(2, 100, 1'b1);
        chk("sat_conv_cnt_7", cc[2], 7);

        // Fill both stages, then reset mid-flight.
        @(negedge clk);
        ordy[2] = 1'b0;
        iv[2] = 1'b1;
        id[2] = 8'h03;
        im[2] = 2'd0;
        @(negedge clk);
        id[2] = 8'h09;
        im[2] = 2'd2;
        @(negedge clk);
        iv[2] = 1'b0;
        #1;
        chk("full_out_valid", ov[2], 1);
        chk("full_in_ready", ir[2], 0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk("midrst_out_valid", ov[k], 0);
            chk("midrst_conv_cnt", cc[k], 0);
            chk("midrst_err_cnt", ec[k], 0);
            chk("midrst_out_data", od[k], 0);
            mcnt[k] = 0;
            merr[k] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        ordy = '1;
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                chk("post_rst_out_valid", ov[k], 0);
                chk("post_rst_in_ready", ir[k], 1);
            end
        end
        chk("post_rst_conv_cnt", cc[2], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
